// File: rtl/roce_wq_pkg.sv
// -----------------------------------------------------------------------------
// roce_wq_pkg
// Shared types and helpers for the RoCE work queue and its request arbiter.
//   wr_req_t      : one work request (one beat on the request streams)
//   QPN_BASE      : first supported local queue pair number
//   qpn_in_range  : true when a local QPN addresses a supported queue pair
// -----------------------------------------------------------------------------
package roce_wq_pkg;

  localparam int QPN_W      = 24;
  localparam int LEN_W      = 32;
  localparam int ADDR_W     = 64;
  localparam int IMM_W      = 32;
  localparam int DROP_CNT_W = 16;

  localparam logic [QPN_W-1:0] QPN_BASE = 24'h000100;

  typedef struct packed {
    logic [QPN_W-1:0]  loc_qp;
    logic [LEN_W-1:0]  dma_length;
    logic [ADDR_W-1:0] addr_offset;
    logic              is_immediate;
    logic [IMM_W-1:0]  immediate_data;
    logic              tx_type;
  } wr_req_t;

  // Supported QPNs share the upper bits of QPN_BASE; the low byte indexes the
  // queue pair, so everything above the index bits must be zero.
  function automatic logic qpn_in_range(input logic [QPN_W-1:0] qpn, input int max_qps);
    logic [7:0] above_index;
    above_index = qpn[7:0] >> $clog2(max_qps);
    return (qpn[QPN_W-1:8] == QPN_BASE[QPN_W-1:8]) && (above_index == 8'd0);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter. The search starts at the port after the last winner and
// picks the first requesting port. The pointer only moves when a grant is
// actually issued (enable && |req).
//   clk, rst     : clock, synchronous active-high reset (pointer -> port 0)
//   req          : request vector, one bit per port
//   enable       : arbitration allowed this cycle
//   grant        : one-hot grant (all zero when nothing is granted)
//   grant_idx    : index of the granted port
//   grant_valid  : a grant is issued this cycle
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter  int N     = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             enable,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  // Port at which the next search begins.
  logic [IDX_W-1:0] ptr_q;

  always_comb begin
    int idx;
    // NOTE: every output of a combinational block gets a default before any
    // branch, otherwise unassigned paths infer latches.
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= N) idx = idx - N;
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'(idx);
      end
    end
    if (!enable) begin
      grant_valid = 1'b0;
    end
    if (grant_valid) begin
      grant[grant_idx] = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (grant_valid) begin
      ptr_q <= (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/roce_wr_req_arbiter.sv
// -----------------------------------------------------------------------------
// roce_wr_req_arbiter
// Merges NUM_PORTS work-request streams into the single work-queue request
// input. Requests with an unsupported local QPN are consumed and dropped,
// reported by a one-cycle pulse and a saturating counter. The output is a
// registered slice: one cycle of latency, one request per cycle sustained.
//   clk, rst               : clock, synchronous active-high reset
//   s_wr_req_*             : per-port request streams (fields packed per port)
//   m_wr_req_*             : merged request stream towards the work queue
//   m_wr_req_port          : source port of the current output request
//   m_drop_valid/_port     : pulse and source port of a dropped request
//   m_drop_count           : saturating number of dropped requests
// -----------------------------------------------------------------------------
module roce_wr_req_arbiter
  import roce_wq_pkg::*;
#(
  parameter  int NUM_PORTS       = 4,
  parameter  int MAX_QUEUE_PAIRS = 4,
  localparam int PORT_W          = $clog2(NUM_PORTS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        s_wr_req_valid,
  output logic [NUM_PORTS-1:0]        s_wr_req_ready,
  input  logic [NUM_PORTS*QPN_W-1:0]  s_wr_req_loc_qp,
  input  logic [NUM_PORTS*LEN_W-1:0]  s_wr_req_dma_length,
  input  logic [NUM_PORTS*ADDR_W-1:0] s_wr_req_addr_offset,
  input  logic [NUM_PORTS-1:0]        s_wr_req_is_immediate,
  input  logic [NUM_PORTS*IMM_W-1:0]  s_wr_req_immediate_data,
  input  logic [NUM_PORTS-1:0]        s_wr_req_tx_type,
  output logic                        m_wr_req_valid,
  input  logic                        m_wr_req_ready,
  output logic [QPN_W-1:0]            m_wr_req_loc_qp,
  output logic [LEN_W-1:0]            m_wr_req_dma_length,
  output logic [ADDR_W-1:0]           m_wr_req_addr_offset,
  output logic                        m_wr_req_is_immediate,
  output logic [IMM_W-1:0]            m_wr_req_immediate_data,
  output logic                        m_wr_req_tx_type,
  output logic [PORT_W-1:0]           m_wr_req_port,
  output logic                        m_drop_valid,
  output logic [PORT_W-1:0]           m_drop_port,
  output logic [DROP_CNT_W-1:0]       m_drop_count
);

  wr_req_t           req [NUM_PORTS];
  wr_req_t           sel;
  wr_req_t           out_req;
  logic              slot_free;
  logic              arb_en;
  logic              grant_valid;
  logic [PORT_W-1:0] grant_idx;
  logic              sel_ok;

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      req[p].loc_qp         = s_wr_req_loc_qp[p*QPN_W +: QPN_W];
      req[p].dma_length     = s_wr_req_dma_length[p*LEN_W +: LEN_W];
      req[p].addr_offset    = s_wr_req_addr_offset[p*ADDR_W +: ADDR_W];
      req[p].is_immediate   = s_wr_req_is_immediate[p];
      req[p].immediate_data = s_wr_req_immediate_data[p*IMM_W +: IMM_W];
      req[p].tx_type        = s_wr_req_tx_type[p];
    end
  end

  // The slot may be drained and refilled in the same cycle. Holding off during
  // reset keeps any port from seeing a handshake that the reset would lose.
  assign slot_free = !m_wr_req_valid || m_wr_req_ready;
  assign arb_en    = slot_free && !rst;

  rr_arbiter #(.N(NUM_PORTS)) u_rr_arbiter (
    .clk         (clk),
    .rst         (rst),
    .req         (s_wr_req_valid),
    .enable      (arb_en),
    .grant       (s_wr_req_ready),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign sel    = req[grant_idx];
  assign sel_ok = qpn_in_range(sel.loc_qp, MAX_QUEUE_PAIRS);

  // Control state: valid flags and the drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_wr_req_valid <= 1'b0;
      m_drop_valid   <= 1'b0;
      m_drop_count   <= '0;
    end else begin
      m_drop_valid <= 1'b0;
      if (slot_free) begin
        m_wr_req_valid <= grant_valid && sel_ok;
        if (grant_valid && !sel_ok) begin
          m_drop_valid <= 1'b1;
          if (m_drop_count != '1) begin
            m_drop_count <= m_drop_count + 1'b1;
          end
        end
      end
    end
  end

  // NOTE: the datapath registers carry no reset; they are qualified by the
  // valid flags, so resetting them would only add fanout on rst.
  always_ff @(posedge clk) begin
    if (slot_free && grant_valid) begin
      if (sel_ok) begin
        out_req       <= sel;
        m_wr_req_port <= grant_idx;
      end else begin
        m_drop_port <= grant_idx;
      end
    end
  end

  assign m_wr_req_loc_qp         = out_req.loc_qp;
  assign m_wr_req_dma_length     = out_req.dma_length;
  assign m_wr_req_addr_offset    = out_req.addr_offset;
  assign m_wr_req_is_immediate   = out_req.is_immediate;
  assign m_wr_req_immediate_data = out_req.immediate_data;
  assign m_wr_req_tx_type        = out_req.tx_type;

endmodule

// File: tb/tb_roce_wr_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_roce_wr_req_arbiter
// Self-checking bench. A reference model predicts grants, forwarded requests
// and drops from the arbitration rules; forwarded requests and drops go into
// queues that a separate monitor drains whenever the DUT presents them.
// -----------------------------------------------------------------------------
module tb_roce_wr_req_arbiter;
  import roce_wq_pkg::*;

  localparam int N    = 4;
  localparam int MAXQ = 4;
  localparam int PW   = $clog2(N);

  typedef struct {
    wr_req_t req;
    int      port;
  } out_item_t;

  typedef struct {
    int          port;
    logic [15:0] count;
  } drop_item_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [N-1:0]         drv_vld = '0;
  wr_req_t              drv_req [N];
  logic                 m_rdy = 1'b0;

  logic [N-1:0]         s_wr_req_ready;
  logic [N*24-1:0]      s_loc_qp;
  logic [N*32-1:0]      s_dma_length;
  logic [N*64-1:0]      s_addr_offset;
  logic [N-1:0]         s_is_immediate;
  logic [N*32-1:0]      s_immediate_data;
  logic [N-1:0]         s_tx_type;
  logic                 m_wr_req_valid;
  logic [23:0]          m_wr_req_loc_qp;
  logic [31:0]          m_wr_req_dma_length;
  logic [63:0]          m_wr_req_addr_offset;
  logic                 m_wr_req_is_immediate;
  logic [31:0]          m_wr_req_immediate_data;
  logic                 m_wr_req_tx_type;
  logic [PW-1:0]        m_wr_req_port;
  logic                 m_drop_valid;
  logic [PW-1:0]        m_drop_port;
  logic [15:0]          m_drop_count;

  always #5 clk = ~clk;

  always_comb begin
    s_loc_qp         = '0;
    s_dma_length     = '0;
    s_addr_offset    = '0;
    s_is_immediate   = '0;
    s_immediate_data = '0;
    s_tx_type        = '0;
    for (int p = 0; p < N; p++) begin
      s_loc_qp[p*24 +: 24]         = drv_req[p].loc_qp;
      s_dma_length[p*32 +: 32]     = drv_req[p].dma_length;
      s_addr_offset[p*64 +: 64]    = drv_req[p].addr_offset;
      s_is_immediate[p]            = drv_req[p].is_immediate;
      s_immediate_data[p*32 +: 32] = drv_req[p].immediate_data;
      s_tx_type[p]                 = drv_req[p].tx_type;
    end
  end

  roce_wr_req_arbiter #(.NUM_PORTS(N), .MAX_QUEUE_PAIRS(MAXQ)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .s_wr_req_valid          (drv_vld),
    .s_wr_req_ready          (s_wr_req_ready),
    .s_wr_req_loc_qp         (s_loc_qp),
    .s_wr_req_dma_length     (s_dma_length),
    .s_wr_req_addr_offset    (s_addr_offset),
    .s_wr_req_is_immediate   (s_is_immediate),
    .s_wr_req_immediate_data (s_immediate_data),
    .s_wr_req_tx_type        (s_tx_type),
    .m_wr_req_valid          (m_wr_req_valid),
    .m_wr_req_ready          (m_rdy),
    .m_wr_req_loc_qp         (m_wr_req_loc_qp),
    .m_wr_req_dma_length     (m_wr_req_dma_length),
    .m_wr_req_addr_offset    (m_wr_req_addr_offset),
    .m_wr_req_is_immediate   (m_wr_req_is_immediate),
    .m_wr_req_immediate_data (m_wr_req_immediate_data),
    .m_wr_req_tx_type        (m_wr_req_tx_type),
    .m_wr_req_port           (m_wr_req_port),
    .m_drop_valid            (m_drop_valid),
    .m_drop_port             (m_drop_port),
    .m_drop_count            (m_drop_count)
  );

  // ---------------------------------------------------------------- checking
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  out_item_t   out_q[$];
  drop_item_t  drop_q[$];
  int          obs_grants[$];
  logic [N-1:0] hs = '0;

  bit          mdl_valid      = 1'b0;
  bit          mdl_drop_valid = 1'b0;
  logic [15:0] mdl_count      = '0;
  int          mdl_ptr        = 0;

  int gen_mask = 0;
  int gen_pct  = 0;
  int bad_pct  = 0;
  int rdy_pct  = 100;

  function automatic bit qpn_ok(input logic [23:0] qpn);
    return (int'(qpn) >= 'h100) && (int'(qpn) < 'h100 + MAXQ);
  endfunction

  function automatic wr_req_t rand_req(input bit bad);
    wr_req_t r;
    r.dma_length     = $urandom;
    r.addr_offset    = {$urandom, $urandom};
    r.is_immediate   = 1'($urandom_range(1));
    r.immediate_data = $urandom;
    r.tx_type        = 1'($urandom_range(1));
    if (!bad) begin
      r.loc_qp = 24'(32'h100 + $urandom_range(MAXQ - 1));
    end else begin
      case ($urandom_range(4))
        0:       r.loc_qp = 24'h000200;
        1:       r.loc_qp = 24'h0000FF;
        2:       r.loc_qp = 24'(32'h100 + MAXQ);
        3:       r.loc_qp = 24'h000000;
        default: r.loc_qp = 24'($urandom) | 24'h010000;
      endcase
    end
    return r;
  endfunction

  // Runs at the falling edge: compares registered state, predicts this
  // cycle's grant and advances the model to the state after the next edge.
  task automatic model_step();
    int g;
    int p;
    bit free;
    logic [N-1:0] exp_rdy;
    check("m_wr_req_valid", 160'(m_wr_req_valid), 160'(mdl_valid));
    check("m_drop_valid", 160'(m_drop_valid), 160'(mdl_drop_valid));
    check("m_drop_count", 160'(m_drop_count), 160'(mdl_count));
    for (int i = 0; i < N; i++) begin
      if (s_wr_req_ready[i] && drv_vld[i]) obs_grants.push_back(i);
    end
    hs   = s_wr_req_ready & drv_vld;
    free = !mdl_valid || m_rdy;
    g    = -1;
    if (free && !rst) begin
      for (int i = 0; i < N; i++) begin
        p = (mdl_ptr + i) % N;
        if (g < 0 && drv_vld[p]) g = p;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("s_wr_req_ready", 160'(s_wr_req_ready), 160'(exp_rdy));
    if (rst) begin
      mdl_valid      = 1'b0;
      mdl_drop_valid = 1'b0;
      mdl_count      = '0;
      mdl_ptr        = 0;
      out_q.delete();
      drop_q.delete();
    end else begin
      mdl_drop_valid = 1'b0;
      if (g >= 0) begin
        mdl_ptr = (g + 1) % N;
        if (qpn_ok(drv_req[g].loc_qp)) begin
          out_q.push_back('{req: drv_req[g], port: g});
          mdl_valid = 1'b1;
        end else begin
          if (mdl_count != 16'hFFFF) mdl_count = mdl_count + 16'd1;
          drop_q.push_back('{port: g, count: mdl_count});
          mdl_drop_valid = 1'b1;
          mdl_valid      = 1'b0;
        end
      end else if (free) begin
        mdl_valid = 1'b0;
      end
    end
  endtask

  // ---------------------------------------------------------------- monitor
  always @(negedge clk) begin
    out_item_t  e;
    drop_item_t d;
    wr_req_t    got;
    if (!rst) begin
      if (m_wr_req_valid && m_rdy) begin
        if (out_q.size() == 0) begin
          check("unexpected_output", 160'(1), 160'(0));
        end else begin
          e = out_q.pop_front();
          got.loc_qp         = m_wr_req_loc_qp;
          got.dma_length     = m_wr_req_dma_length;
          got.addr_offset    = m_wr_req_addr_offset;
          got.is_immediate   = m_wr_req_is_immediate;
          got.immediate_data = m_wr_req_immediate_data;
          got.tx_type        = m_wr_req_tx_type;
          check("out_fields", 160'(got), 160'(e.req));
          check("out_port", 160'(m_wr_req_port), 160'(e.port));
        end
      end
      if (m_drop_valid) begin
        if (drop_q.size() == 0) begin
          check("unexpected_drop", 160'(1), 160'(0));
        end else begin
          d = drop_q.pop_front();
          check("drop_port", 160'(m_drop_port), 160'(d.port));
          check("drop_count_at_pulse", 160'(m_drop_count), 160'(d.count));
        end
      end
    end
  end

  // ---------------------------------------------------------------- driver
  task automatic drive();
    drv_vld = drv_vld & ~hs;
    for (int p = 0; p < N; p++) begin
      if (!drv_vld[p] && gen_mask[p] && int'($urandom_range(99)) < gen_pct) begin
        drv_vld[p] = 1'b1;
        drv_req[p] = rand_req(int'($urandom_range(99)) < bad_pct);
      end
    end
    m_rdy = int'($urandom_range(99)) < rdy_pct;
  endtask

  task automatic cycle();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic set_req(input int p, input logic [23:0] qpn, input logic [31:0] len);
    wr_req_t r;
    r            = rand_req(1'b0);
    r.loc_qp     = qpn;
    r.dma_length = len;
    drv_req[p]   = r;
    drv_vld[p]   = 1'b1;
  endtask

  task automatic drain();
    gen_mask = 0;
    rdy_pct  = 100;
    for (int i = 0; i < 50; i++) begin
      cycle();
      if (drv_vld == '0 && !m_wr_req_valid) break;
    end
    check("drain_done", 160'({drv_vld, m_wr_req_valid}), 160'(0));
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    wr_req_t snap;
    int      snap_port;
    int      exp2 [6] = '{0, 1, 2, 3, 0, 1};
    for (int p = 0; p < N; p++) drv_req[p] = rand_req(1'b0);

    // Reset state.
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) cycle();
    check("rst_m_valid", 160'(m_wr_req_valid), 160'(0));
    check("rst_drop_count", 160'(m_drop_count), 160'(0));
    rst = 1'b0;

    // Fairness from reset: all ports valid, output always ready.
    obs_grants.delete();
    gen_mask = 'hF; gen_pct = 100; bad_pct = 0; rdy_pct = 100;
    for (int i = 0; i < 7; i++) cycle();
    check("fair_count", 160'(obs_grants.size()), 160'(6));
    for (int i = 0; i < 6; i++) begin
      if (i < obs_grants.size()) check("fair_order", 160'(obs_grants[i]), 160'(exp2[i]));
    end
    drain();

    // Single request on port 1.
    set_req(1, 24'h000102, 32'h40);
    cycle();
    check("t1_valid", 160'(m_wr_req_valid), 160'(1));
    check("t1_port", 160'(m_wr_req_port), 160'(1));
    check("t1_qp", 160'(m_wr_req_loc_qp), 160'(24'h000102));
    check("t1_len", 160'(m_wr_req_dma_length), 160'(32'h40));
    drain();

    // Stall for five cycles with the output valid, then release.
    gen_mask = 'hF; gen_pct = 100; rdy_pct = 100;
    for (int i = 0; i < 3; i++) cycle();
    rdy_pct = 0;
    cycle();
    snap.loc_qp         = m_wr_req_loc_qp;
    snap.dma_length     = m_wr_req_dma_length;
    snap.addr_offset    = m_wr_req_addr_offset;
    snap.is_immediate   = m_wr_req_is_immediate;
    snap.immediate_data = m_wr_req_immediate_data;
    snap.tx_type        = m_wr_req_tx_type;
    snap_port           = int'(m_wr_req_port);
    obs_grants.delete();
    for (int i = 0; i < 5; i++) begin
      if (i == 4) rdy_pct = 100;
      cycle();
      check("stall_valid", 160'(m_wr_req_valid), 160'(1));
      check("stall_fields", 160'({m_wr_req_loc_qp, m_wr_req_dma_length, m_wr_req_addr_offset,
                                   m_wr_req_is_immediate, m_wr_req_immediate_data, m_wr_req_tx_type}),
            160'(snap));
      check("stall_port", 160'(m_wr_req_port), 160'(snap_port));
    end
    check("stall_no_grant", 160'(obs_grants.size()), 160'(0));
    cycle();
    check("release_grants", 160'(obs_grants.size()), 160'(1));
    if (obs_grants.size() > 0) check("release_port", 160'(obs_grants[0]), 160'((snap_port + 1) % N));
    drain();

    // Invalid QPN on port 2 is dropped; port 3 is next.
    set_req(1, 24'h000101, 32'h10);
    cycle();
    set_req(0, 24'h000100, 32'h20);
    set_req(2, 24'h000200, 32'h30);
    set_req(3, 24'h000103, 32'h40);
    obs_grants.delete();
    cycle();
    check("t4_drop_valid", 160'(m_drop_valid), 160'(1));
    check("t4_drop_port", 160'(m_drop_port), 160'(2));
    check("t4_drop_count", 160'(m_drop_count), 160'(1));
    check("t4_no_output", 160'(m_wr_req_valid), 160'(0));
    cycle();
    check("t4_drop_ends", 160'(m_drop_valid), 160'(0));
    check("t4_grants", 160'(obs_grants.size()), 160'(2));
    if (obs_grants.size() == 2) check("t4_next_port", 160'(obs_grants[1]), 160'(3));
    drain();

    // Randomized traffic with stalls and bad QPNs.
    gen_mask = 'hF; gen_pct = 40; bad_pct = 15; rdy_pct = 70;
    for (int i = 0; i < 2000; i++) cycle();
    drain();

    // Reset during a stall with ports 1 and 3 waiting.
    rdy_pct = 0;
    set_req(0, 24'h000100, 32'h50);
    cycle();
    set_req(1, 24'h000101, 32'h60);
    set_req(3, 24'h000102, 32'h70);
    cycle();
    rst = 1'b1;
    cycle();
    check("t6_rst_valid", 160'(m_wr_req_valid), 160'(0));
    cycle();
    rst = 1'b0;
    rdy_pct = 100;
    obs_grants.delete();
    cycle();
    check("t6_grants", 160'(obs_grants.size()), 160'(1));
    if (obs_grants.size() > 0) check("t6_first_port", 160'(obs_grants[0]), 160'(1));
    drain();

    // Drive the drop counter into saturation.
    gen_mask = 'hF; gen_pct = 100; bad_pct = 100; rdy_pct = 100;
    for (int i = 0; i < 70000 && mdl_count != 16'hFFFF; i++) cycle();
    check("sat_reached", 160'(m_drop_count), 160'(16'hFFFF));
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("sat_pulse", 160'(m_drop_valid), 160'(1));
      check("sat_hold", 160'(m_drop_count), 160'(16'hFFFF));
    end
    drain();
    cycle();

    check("out_q_empty", 160'(out_q.size()), 160'(0));
    check("drop_q_empty", 160'(drop_q.size()), 160'(0));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
